// File: rtl/tmr_mon_pkg.sv
// Shared types and helpers for the TMR fault monitor and its replica trackers.
package tmr_mon_pkg;

    localparam int NUM_REP = 3;

    // Health of a single replica as seen by the monitor.
    typedef enum logic [1:0] {
        OK      = 2'd0,
        SUSPECT = 2'd1,
        FAULTY  = 2'd2,
        SCRUB   = 2'd3
    } rep_state_t;

    typedef logic [1:0] rep_idx_t;

    // Two-out-of-three majority of single bits.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/tmr_replica_tracker.sv
// Health tracker for one replica: OK/SUSPECT/FAULTY/SCRUB state machine,
// consecutive-disagreement streak and a saturating error counter.
module tmr_replica_tracker
    import tmr_mon_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int PERSIST = 3
)
(
    input  logic             i_clk,
    input  logic             i_rst,       // asynchronous, active-low
    input  logic             i_dis,       // replica disagrees with the vote
    input  logic             i_enable,
    input  logic             i_clr_cnt,
    input  logic             i_grant,     // arbiter picked this replica for scrub
    input  logic             i_ack,       // scrub of this replica completed
    output rep_state_t       o_state,
    output logic [CNT_W-1:0] o_err_cnt
);

    // Streak must be able to hold the value PERSIST itself.
    localparam int                   STREAK_W   = $clog2(PERSIST + 1);
    localparam logic [STREAK_W-1:0]  STREAK_ONE = STREAK_W'(1);
    localparam logic [STREAK_W-1:0]  STREAK_TOP = STREAK_W'(PERSIST);
    localparam logic [CNT_W-1:0]     CNT_MAX    = '1;

    rep_state_t          r_state;
    rep_state_t          w_next_state;
    logic [STREAK_W-1:0] r_streak;
    logic [STREAK_W-1:0] w_next_streak;
    logic [STREAK_W-1:0] w_streak_inc;
    logic [CNT_W-1:0]    r_err_cnt;
    logic                w_active_dis;
    logic                w_cnt_en;

    assign w_active_dis = i_enable & i_dis;
    assign w_streak_inc = r_streak + STREAK_ONE;

    // State and streak registers.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state  <= OK;
            r_streak <= '0;
        end else begin
            r_state  <= w_next_state;
            r_streak <= w_next_streak;
        end
    end

    // Next-state and next-streak logic.
    // NOTE: defaults are assigned first so no path leaves an output unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        w_next_state  = r_state;
        w_next_streak = r_streak;
        case (r_state)
            OK: begin
                if (w_active_dis) begin
                    w_next_streak = STREAK_ONE;
                    w_next_state  = (PERSIST == 1) ? FAULTY : SUSPECT;
                end
            end
            SUSPECT: begin
                if (w_active_dis) begin
                    w_next_streak = w_streak_inc;
                    if (w_streak_inc >= STREAK_TOP) begin
                        w_next_state = FAULTY;
                    end
                end else if (i_enable) begin
                    w_next_streak = '0;
                    w_next_state  = OK;
                end
            end
            FAULTY: begin
                // Streak is frozen; only the arbiter can move us on.
                if (i_grant) begin
                    w_next_state = SCRUB;
                end
            end
            SCRUB: begin
                // Disagreement during reload is expected and ignored.
                if (i_ack) begin
                    w_next_streak = '0;
                    w_next_state  = OK;
                end
            end
            default: begin
                w_next_streak = '0;
                w_next_state  = OK;
            end
        endcase
    end

    // Output decode: exported state and counter-increment qualifier.
    always_comb begin
        o_state  = r_state;
        w_cnt_en = w_active_dis & (r_state != SCRUB);
    end

    // Saturating error counter; a clear beats a same-cycle increment.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_err_cnt <= '0;
        end else if (i_clr_cnt) begin
            r_err_cnt <= '0;
        end else if (w_cnt_en && (r_err_cnt != CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign o_err_cnt = r_err_cnt;

endmodule

// File: rtl/tmr_fault_monitor.sv
// Majority voter and health monitor for three replicas of a WIDTH-bit register
// with serial output. Tracks each replica, flags persistent offenders and
// drives a single-outstanding scrub request/acknowledge handshake.
module tmr_fault_monitor
    import tmr_mon_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int CNT_W   = 8,
    parameter int PERSIST = 3
)
(
    input  logic               i_clk,
    input  logic               i_rst,                   // asynchronous, active-low
    input  logic               i_enable,
    input  logic [WIDTH-1:0]   i_rep_data [NUM_REP],
    input  logic [NUM_REP-1:0] i_rep_sout,
    input  logic               i_clr_cnt,
    input  logic               i_scrub_ack,
    output logic [WIDTH-1:0]   o_voted_data,
    output logic               o_voted_sout,
    output logic               o_mismatch,
    output logic               o_multi_err,
    output logic [NUM_REP-1:0] o_fault_mask,
    output logic [CNT_W-1:0]   o_err_cnt [NUM_REP],
    output logic               o_scrub_req,
    output rep_idx_t           o_scrub_idx
);

    logic [WIDTH-1:0]   w_voted_data;
    logic               w_voted_sout;
    logic [NUM_REP-1:0] w_dis;
    logic [NUM_REP-1:0] w_live_dis;
    logic [NUM_REP-1:0] w_grant;
    logic [NUM_REP-1:0] w_ack;
    logic               w_grant_valid;
    rep_idx_t           w_grant_idx;
    logic               w_ack_fire;
    rep_state_t         w_state [NUM_REP];

    logic               r_mismatch;
    logic               r_multi_err;
    logic               r_scrub_req;
    rep_idx_t           r_scrub_idx;

    // Bitwise majority vote; always active, faulty replicas still take part.
    always_comb begin
        w_voted_data = '0;
        for (int b = 0; b < WIDTH; b++) begin
            w_voted_data[b] = maj3(i_rep_data[0][b], i_rep_data[1][b], i_rep_data[2][b]);
        end
        w_voted_sout = maj3(i_rep_sout[0], i_rep_sout[1], i_rep_sout[2]);
    end

    // Per-replica disagreement, plus the enable-qualified view used for
    // status flags (replicas under scrub are expected to disagree).
    always_comb begin
        w_dis      = '0;
        w_live_dis = '0;
        for (int i = 0; i < NUM_REP; i++) begin
            w_dis[i]      = (i_rep_data[i] != w_voted_data) | (i_rep_sout[i] != w_voted_sout);
            w_live_dis[i] = i_enable & w_dis[i] & (w_state[i] != SCRUB);
        end
    end

    // Arbiter: lowest-index FAULTY replica wins, only while no request is open.
    always_comb begin
        w_grant       = '0;
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_ack_fire    = r_scrub_req & i_scrub_ack;
        w_ack         = '0;
        for (int i = 0; i < NUM_REP; i++) begin
            if (!r_scrub_req && !w_grant_valid && (w_state[i] == FAULTY)) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = rep_idx_t'(i);
                w_grant[i]    = 1'b1;
            end
            w_ack[i] = w_ack_fire & (r_scrub_idx == rep_idx_t'(i));
        end
    end

    // One health tracker per replica.
    for (genvar g = 0; g < NUM_REP; g++) begin : g_rep
        tmr_replica_tracker #(
            .CNT_W   (CNT_W),
            .PERSIST (PERSIST)
        ) u_tracker (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_dis     (w_dis[g]),
            .i_enable  (i_enable),
            .i_clr_cnt (i_clr_cnt),
            .i_grant   (w_grant[g]),
            .i_ack     (w_ack[g]),
            .o_state   (w_state[g]),
            .o_err_cnt (o_err_cnt[g])
        );
    end

    // Scrub request register: ack closes the request, which forces at least
    // one idle cycle before the next grant can be taken.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_scrub_req <= 1'b0;
            r_scrub_idx <= '0;
        end else if (w_ack_fire) begin
            r_scrub_req <= 1'b0;
        end else if (w_grant_valid) begin
            r_scrub_req <= 1'b1;
            r_scrub_idx <= w_grant_idx;
        end
    end

    // Registered disagreement flags; zero whenever monitoring is disabled.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_mismatch  <= 1'b0;
            r_multi_err <= 1'b0;
        end else begin
            r_mismatch  <= |w_live_dis;
            r_multi_err <= ($countones(w_live_dis) >= 2);
        end
    end

    // Fault mask covers both the waiting and the reloading phase.
    always_comb begin
        o_fault_mask = '0;
        for (int i = 0; i < NUM_REP; i++) begin
            o_fault_mask[i] = (w_state[i] == FAULTY) || (w_state[i] == SCRUB);
        end
    end

    assign o_voted_data = w_voted_data;
    assign o_voted_sout = w_voted_sout;
    assign o_mismatch   = r_mismatch;
    assign o_multi_err  = r_multi_err;
    assign o_scrub_req  = r_scrub_req;
    assign o_scrub_idx  = r_scrub_idx;

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Self-checking bench for tmr_fault_monitor: directed scenarios from the
// behaviour description plus a randomized run against a reference model.
module tb_tmr_fault_monitor;

    localparam int WIDTH   = 4;
    localparam int CNT_W   = 2;
    localparam int PERSIST = 3;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             enable;
    logic [WIDTH-1:0] rep_data [3];
    logic [2:0]       rep_sout;
    logic             clr_cnt;
    logic             scrub_ack;
    logic [WIDTH-1:0] voted_data;
    logic             voted_sout;
    logic             mismatch;
    logic             multi_err;
    logic [2:0]       fault_mask;
    logic [CNT_W-1:0] err_cnt [3];
    logic             scrub_req;
    logic [1:0]       scrub_idx;

    int total = 0;
    int bad   = 0;

    tmr_fault_monitor #(
        .WIDTH   (WIDTH),
        .CNT_W   (CNT_W),
        .PERSIST (PERSIST)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_enable     (enable),
        .i_rep_data   (rep_data),
        .i_rep_sout   (rep_sout),
        .i_clr_cnt    (clr_cnt),
        .i_scrub_ack  (scrub_ack),
        .o_voted_data (voted_data),
        .o_voted_sout (voted_sout),
        .o_mismatch   (mismatch),
        .o_multi_err  (multi_err),
        .o_fault_mask (fault_mask),
        .o_err_cnt    (err_cnt),
        .o_scrub_req  (scrub_req),
        .o_scrub_idx  (scrub_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [WIDTH-1:0] w);
        for (int i = 0; i < 3; i++) rep_data[i] = w;
        rep_sout = 3'b000;
    endtask

    // Majority by counting ones per bit position.
    function automatic logic [WIDTH-1:0] vote_word(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic [WIDTH-1:0] c);
        logic [WIDTH-1:0] r;
        int ones;
        r = '0;
        for (int k = 0; k < WIDTH; k++) begin
            ones = int'(a[k]) + int'(b[k]) + int'(c[k]);
            r[k] = (ones >= 2);
        end
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b0; enable = 1'b1; clr_cnt = 1'b0; scrub_ack = 1'b0;
        set_all(4'b0110);
        tick(); tick();
        total++; if (voted_data !== 4'b0110) begin bad++; $display("FAIL reset_vote got=%b exp=0110", voted_data); end
        total++; if ({mismatch, multi_err, fault_mask, scrub_req, scrub_idx} !== 8'd0) begin
            bad++; $display("FAIL reset_outs got=%b exp=0", {mismatch, multi_err, fault_mask, scrub_req, scrub_idx}); end
        total++; if ({err_cnt[0], err_cnt[1], err_cnt[2]} !== '0) begin
            bad++; $display("FAIL reset_cnt got=%0d,%0d,%0d exp=0", err_cnt[0], err_cnt[1], err_cnt[2]); end
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL reset_idle_mismatch cyc=%0d got=%b exp=0", c, mismatch); end
        end
        total++; if ({fault_mask, scrub_req} !== 4'd0) begin bad++; $display("FAIL reset_idle_state got=%b exp=0", {fault_mask, scrub_req}); end
    endtask

    task automatic test_transient();
        rep_data[2] = 4'b1111;
        #1;
        total++; if (voted_data !== 4'b0110) begin bad++; $display("FAIL trans_vote got=%b exp=0110", voted_data); end
        tick();
        total++; if (mismatch !== 1'b1) begin bad++; $display("FAIL trans_mis_hi got=%b exp=1", mismatch); end
        total++; if (err_cnt[2] !== 2'd1) begin bad++; $display("FAIL trans_cnt got=%0d exp=1", err_cnt[2]); end
        rep_data[2] = 4'b0110;
        tick();
        total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL trans_mis_lo got=%b exp=0", mismatch); end
        total++; if (fault_mask !== 3'b000) begin bad++; $display("FAIL trans_mask got=%b exp=000", fault_mask); end
        total++; if (err_cnt[2] !== 2'd1) begin bad++; $display("FAIL trans_cnt_hold got=%0d exp=1", err_cnt[2]); end
    endtask

    task automatic test_persistent();
        rep_data[1] = 4'b0111;
        tick(); tick();
        total++; if (fault_mask !== 3'b000) begin bad++; $display("FAIL pers_early_mask got=%b exp=000", fault_mask); end
        tick();
        total++; if (fault_mask !== 3'b010) begin bad++; $display("FAIL pers_mask got=%b exp=010", fault_mask); end
        total++; if (scrub_req !== 1'b0) begin bad++; $display("FAIL pers_req_early got=%b exp=0", scrub_req); end
        rep_data[1] = 4'b0110;
        tick();
        total++; if ({scrub_req, scrub_idx} !== 3'b101) begin bad++; $display("FAIL pers_req got=%b exp=101", {scrub_req, scrub_idx}); end
        tick(); tick(); tick();
        total++; if ({scrub_req, scrub_idx, fault_mask} !== 6'b101010) begin
            bad++; $display("FAIL pers_hold got=%b exp=101010", {scrub_req, scrub_idx, fault_mask}); end
        scrub_ack = 1'b1;
        tick();
        scrub_ack = 1'b0;
        total++; if ({scrub_req, fault_mask} !== 4'b0000) begin bad++; $display("FAIL pers_ack got=%b exp=0000", {scrub_req, fault_mask}); end
        tick();
        total++; if (scrub_req !== 1'b0) begin bad++; $display("FAIL pers_idle got=%b exp=0", scrub_req); end
    endtask

    task automatic test_back_to_back();
        rep_data[0] = 4'b0111;
        rep_data[2] = 4'b0100;
        #1;
        total++; if (voted_data !== 4'b0110) begin bad++; $display("FAIL b2b_vote got=%b exp=0110", voted_data); end
        tick();
        total++; if ({mismatch, multi_err} !== 2'b11) begin bad++; $display("FAIL b2b_multi got=%b exp=11", {mismatch, multi_err}); end
        tick(); tick();
        total++; if (fault_mask !== 3'b101) begin bad++; $display("FAIL b2b_mask got=%b exp=101", fault_mask); end
        set_all(4'b0110);
        tick();
        total++; if ({scrub_req, scrub_idx} !== 3'b100) begin bad++; $display("FAIL b2b_first got=%b exp=100", {scrub_req, scrub_idx}); end
        scrub_ack = 1'b1;
        tick();
        scrub_ack = 1'b0;
        total++; if ({scrub_req, fault_mask} !== 4'b0100) begin bad++; $display("FAIL b2b_gap got=%b exp=0100", {scrub_req, fault_mask}); end
        tick();
        total++; if ({scrub_req, scrub_idx} !== 3'b110) begin bad++; $display("FAIL b2b_second got=%b exp=110", {scrub_req, scrub_idx}); end
        scrub_ack = 1'b1;
        tick();
        scrub_ack = 1'b0;
        total++; if ({scrub_req, fault_mask} !== 4'b0000) begin bad++; $display("FAIL b2b_done got=%b exp=0000", {scrub_req, fault_mask}); end
        tick();
    endtask

    task automatic test_saturation();
        logic [6:0] pattern;
        pattern = 7'b1011011;  // bit 0 first: bad,bad,good,bad,bad,good,bad
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        total++; if (err_cnt[1] !== 2'd0) begin bad++; $display("FAIL sat_clr0 got=%0d exp=0", err_cnt[1]); end
        for (int k = 0; k < 7; k++) begin
            rep_data[1] = pattern[k] ? 4'b0010 : 4'b0110;
            tick();
        end
        total++; if (err_cnt[1] !== 2'd3) begin bad++; $display("FAIL sat_cnt got=%0d exp=3", err_cnt[1]); end
        total++; if (fault_mask !== 3'b000) begin bad++; $display("FAIL sat_mask got=%b exp=000", fault_mask); end
        clr_cnt = 1'b1;  // replica 1 still bad: clear beats increment
        tick();
        clr_cnt = 1'b0;
        total++; if (err_cnt[1] !== 2'd0) begin bad++; $display("FAIL sat_clr_win got=%0d exp=0", err_cnt[1]); end
        enable = 1'b0;
        tick(); tick(); tick();
        total++; if ({err_cnt[1], fault_mask, mismatch} !== 6'd0) begin
            bad++; $display("FAIL sat_hold got=%b exp=0", {err_cnt[1], fault_mask, mismatch}); end
        enable = 1'b1;
        tick();  // streak 2 was held, third enabled disagreement faults the replica
        total++; if (fault_mask !== 3'b010) begin bad++; $display("FAIL sat_streak_hold got=%b exp=010", fault_mask); end
        total++; if (err_cnt[1] !== 2'd1) begin bad++; $display("FAIL sat_cnt_resume got=%0d exp=1", err_cnt[1]); end
        rep_data[1] = 4'b0110;
        tick();
        scrub_ack = 1'b1;
        tick();
        scrub_ack = 1'b0;
        tick();
        total++; if ({scrub_req, fault_mask} !== 4'b0000) begin bad++; $display("FAIL sat_cleanup got=%b exp=0000", {scrub_req, fault_mask}); end
    endtask

    task automatic test_reset_mid_scrub();
        rep_data[0] = 4'b1110;
        tick(); tick(); tick();
        set_all(4'b0110);
        tick();
        total++; if ({scrub_req, scrub_idx, fault_mask} !== 6'b100001) begin
            bad++; $display("FAIL rms_req got=%b exp=100001", {scrub_req, scrub_idx, fault_mask}); end
        #2 rst = 1'b0;
        #1;
        total++; if ({scrub_req, fault_mask} !== 4'b0000) begin bad++; $display("FAIL rms_async got=%b exp=0000", {scrub_req, fault_mask}); end
        total++; if (err_cnt[0] !== 2'd0) begin bad++; $display("FAIL rms_cnt got=%0d exp=0", err_cnt[0]); end
        tick();
        rst = 1'b1;
        scrub_ack = 1'b1;
        tick(); tick();
        scrub_ack = 1'b0;
        total++; if ({scrub_req, fault_mask} !== 4'b0000) begin bad++; $display("FAIL rms_late_ack got=%b exp=0000", {scrub_req, fault_mask}); end
    endtask

    // Randomized traffic versus a counting model: each replica is described by
    // its current run of disagreements and whether it is waiting or reloading.
    task automatic test_random();
        int m_run [3];
        bit m_wait [3];
        bit m_reload [3];
        int m_cnt [3];
        bit m_req;
        int m_idx;
        bit m_mis, m_multi;
        int burst [3];
        logic [WIDTH-1:0] good, exp_vote;
        logic gsout, exp_sout;
        bit dis [3];
        bit was_reload;
        bit ackv;
        int grant, live;
        logic [2:0] exp_mask;

        rst = 1'b0; enable = 1'b1; clr_cnt = 1'b0; scrub_ack = 1'b0;
        set_all(4'b0000);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_run[i] = 0; m_wait[i] = 0; m_reload[i] = 0; m_cnt[i] = 0; burst[i] = 0;
        end
        m_req = 0; m_idx = 0; m_mis = 0; m_multi = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            good  = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            gsout = 1'($urandom_range(0, 1));
            for (int i = 0; i < 3; i++) begin
                rep_data[i] = good;
                rep_sout[i] = gsout;
                if (burst[i] == 0 && $urandom_range(0, 99) < 8) burst[i] = $urandom_range(1, 5);
                if (burst[i] > 0) begin
                    case ($urandom_range(0, 2))
                        0: rep_data[i] = good ^ WIDTH'($urandom_range(1, (1 << WIDTH) - 1));
                        1: rep_sout[i] = ~gsout;
                        default: begin
                            rep_data[i] = good ^ WIDTH'($urandom_range(1, (1 << WIDTH) - 1));
                            rep_sout[i] = ~gsout;
                        end
                    endcase
                    burst[i]--;
                end
            end
            enable    = ($urandom_range(0, 99) < 90);
            clr_cnt   = enable && ($urandom_range(0, 99) < 4);
            scrub_ack = m_req ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 5);
            #1;
            exp_vote = vote_word(rep_data[0], rep_data[1], rep_data[2]);
            exp_sout = (int'(rep_sout[0]) + int'(rep_sout[1]) + int'(rep_sout[2])) >= 2;
            total++; if (voted_data !== exp_vote) begin bad++; $display("FAIL rnd_vote cyc=%0d got=%b exp=%b", cyc, voted_data, exp_vote); end
            total++; if (voted_sout !== exp_sout) begin bad++; $display("FAIL rnd_sout cyc=%0d got=%b exp=%b", cyc, voted_sout, exp_sout); end
            for (int i = 0; i < 3; i++) dis[i] = (rep_data[i] != exp_vote) || (rep_sout[i] != exp_sout);

            // Model update for the coming edge.
            ackv  = m_req && scrub_ack;
            grant = -1;
            if (!m_req) for (int i = 0; i < 3; i++) if (grant < 0 && m_wait[i]) grant = i;
            live = 0;
            for (int i = 0; i < 3; i++) begin
                was_reload = m_reload[i];
                if (m_reload[i]) begin
                    if (ackv && m_idx == i) begin m_reload[i] = 0; m_run[i] = 0; end
                end else if (m_wait[i]) begin
                    if (grant == i) begin m_wait[i] = 0; m_reload[i] = 1; end
                end else if (enable) begin
                    if (dis[i]) begin
                        m_run[i]++;
                        if (m_run[i] >= PERSIST) m_wait[i] = 1;
                    end else begin
                        m_run[i] = 0;
                    end
                end
                if (clr_cnt) m_cnt[i] = 0;
                else if (enable && dis[i] && !was_reload && m_cnt[i] < CMAX) m_cnt[i]++;
                if (enable && dis[i] && !was_reload) live++;
            end
            m_mis   = (live > 0);
            m_multi = (live >= 2);
            if (ackv) m_req = 0;
            else if (grant >= 0) begin m_req = 1; m_idx = grant; end

            tick();
            for (int i = 0; i < 3; i++) exp_mask[i] = m_wait[i] | m_reload[i];
            total++; if (mismatch !== m_mis) begin bad++; $display("FAIL rnd_mismatch cyc=%0d got=%b exp=%b", cyc, mismatch, m_mis); end
            total++; if (multi_err !== m_multi) begin bad++; $display("FAIL rnd_multi cyc=%0d got=%b exp=%b", cyc, multi_err, m_multi); end
            total++; if (fault_mask !== exp_mask) begin bad++; $display("FAIL rnd_mask cyc=%0d got=%b exp=%b", cyc, fault_mask, exp_mask); end
            total++; if (scrub_req !== m_req) begin bad++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", cyc, scrub_req, m_req); end
            if (m_req) begin
                total++; if (int'(scrub_idx) != m_idx) begin bad++; $display("FAIL rnd_idx cyc=%0d got=%0d exp=%0d", cyc, scrub_idx, m_idx); end
            end
            for (int i = 0; i < 3; i++) begin
                total++; if (int'(err_cnt[i]) != m_cnt[i]) begin
                    bad++; $display("FAIL rnd_cnt%0d cyc=%0d got=%0d exp=%0d", i, cyc, err_cnt[i], m_cnt[i]); end
            end
        end
        scrub_ack = 1'b0;
        clr_cnt   = 1'b0;
        enable    = 1'b1;
    endtask

    initial begin
        rst = 1'b0; enable = 1'b1; clr_cnt = 1'b0; scrub_ack = 1'b0;
        set_all(4'b0110);
        test_reset();
        test_transient();
        test_persistent();
        test_back_to_back();
        test_saturation();
        test_reset_mid_scrub();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tmr_fault_monitor.md
# tmr_fault_monitor

Downstream companion of the triplicated 4-bit universal register. It consumes the three replica outputs (parallel word plus serial bit) and produces the majority-voted result for the next stage. It tracks per-replica disagreement streaks and saturating error counts, and declares a replica FAULTY after persistent disagreement. It then requests a scrub (replica reload) through a single req/ack handshake.

## Interface
- WIDTH, 4, replica parallel word width
- CNT_W, 8, per-replica error counter width
- PERSIST, 3, consecutive disagreeing cycles that mark a replica FAULTY (≥1)
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- enable  in  1  monitoring enable; low freezes streaks, states and counters
- rep_data[0..2]  in  WIDTH each  replica parallel outputs
- rep_sout[0..2]  in  1 each  replica serial outputs
- clr_cnt  in  1  synchronous clear of all error counters
- scrub_ack  in  1  scrub done for the replica in scrub_idx
- voted_data  out  WIDTH  bitwise majority of rep_data (combinational)
- voted_sout  out  1  majority of rep_sout (combinational)
- mismatch  out  1  registered: any replica disagreed last cycle
- multi_err  out  1  registered: ≥2 replicas disagreed last cycle
- fault_mask  out  3  bit i set while replica i is FAULTY or SCRUB
- err_cnt[0..2]  out  CNT_W each  saturating disagreement counts
- scrub_req  out  1  scrub request, held until acked
- scrub_idx  out  2  replica being scrubbed (0..2), stable while scrub_req

## Operation
- Voting is always active, independent of enable and replica state. FAULTY replicas are not excluded from the vote.
- dis_i = (rep_data[i] != voted_data) | (rep_sout[i] != voted_sout).
- Per-replica FSM with states OK, SUSPECT, FAULTY, SCRUB, plus a streak counter sized for PERSIST:
  - OK: with enable & dis_i, streak=1. Go to FAULTY if PERSIST==1, else to SUSPECT.
  - SUSPECT: with enable & dis_i, streak++. Reaching PERSIST goes to FAULTY. With enable & !dis_i, go to OK and set streak=0.
  - FAULTY: wait for the scrub grant, then go to SCRUB.
  - SCRUB: on scrub_ack, go to OK and set streak=0. dis_i is ignored in SCRUB.
- Scrub arbiter:
  - One request outstanding at a time.
  - Among FAULTY replicas, the lowest index wins.
  - The grant is taken only when scrub_req is low.
  - The handshake runs regardless of enable.
- err_cnt[i]:
  - Increments by 1 on each cycle with enable & dis_i & state≠SCRUB.
  - Saturates at 2^CNT_W−1.
  - clr_cnt wins over a simultaneous increment.
- mismatch and multi_err are computed from enable-qualified dis (SCRUB replicas excluded) and registered.
- enable low: states, streaks and counters hold. mismatch and multi_err register 0.

## Timing
- Reset values: all FSMs OK, streaks 0, err_cnt 0, fault_mask 0, scrub_req 0, scrub_idx 0, mismatch 0, multi_err 0.
- voted_*: zero latency.
- mismatch, multi_err, err_cnt: one cycle after the sampled edge.
- Fault detection latency: dis_i sampled on edges E1..E_PERSIST gives FAULTY and fault_mask[i] after edge E_PERSIST.
- scrub_req and scrub_idx rise after edge E_PERSIST+1, i.e. FAULTY→SCRUB takes one cycle.
- scrub_ack handshake:
  - Sampled only while scrub_req is high; ack while scrub_req is low is ignored.
  - At the ack edge, the replica goes to OK and scrub_req deasserts.
  - scrub_req stays low for at least one cycle before the next grant.
- Reset mid-scrub: everything returns to reset values immediately; the request is dropped.

## Structure
- Shared package tmr_mon_pkg holds:
  - typedef enum logic [1:0] {OK, SUSPECT, FAULTY, SCRUB} rep_state_t
  - typedef logic [1:0] rep_idx_t
  - localparam NUM_REP = 3
- Sub-module tmr_replica_tracker: one replica's FSM, streak and saturating counter.
  - Inputs: dis, enable, clr_cnt, grant, ack.
  - Outputs: state, err_cnt.
  - Instantiated three times.
- Voter, arbiter and status registers live in tmr_fault_monitor.

## Test plan
- Reset: all replicas 4'b0110, sout 0 → voted_data 4'b0110, all outputs at reset values, no mismatch after 10 cycles.
- Transient fault: force rep_data[2]=4'b1111 for 1 cycle with others at 4'b0110 → voted_data stays 4'b0110, mismatch pulses 1 cycle, err_cnt[2]=1, fault_mask 0.
- Persistent fault: rep_data[1]=4'b0111 for 3 cycles, PERSIST=3 → fault_mask=3'b010 after the 3rd edge, scrub_req=1 with scrub_idx=1 next cycle. Ack 4 cycles later → fault_mask=0 and scrub_req=0 the following cycle.
- Two FAULTY replicas (0 and 2) with different wrong bits → multi_err=1. Replica 0 is scrubbed first. scrub_req is low ≥1 cycle, then scrub_idx=2.
- Saturation and clear:
  - CNT_W=2 and 5 disagreeing cycles → err_cnt=3.
  - clr_cnt together with dis → err_cnt=0.
  - enable=0 with dis → counter, streak and state hold.
- rst low during SCRUB → scrub_req=0 and fault_mask=0 immediately (async). A late scrub_ack after reset is ignored.
